// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM pipeline stage performing lw/sw over a req/ack data-memory port.
// Rev 1.0 - initial release.
`default_nettype none

module mem_access_stage #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              EXMEM_valid,
  input  logic [1:0]        EXMEM_WB,
  input  logic              EXMEM_MemRead,
  input  logic              EXMEM_MemWrite,
  input  logic [ADDR_W-1:0] EXMEM_Direccion,
  input  logic [DATA_W-1:0] EXMEM_DatoEscritura,
  input  logic [REG_W-1:0]  EXMEM_MUXRes,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              stall,
  output logic              MEM_valid,
  output logic [1:0]        MEM_WB,
  output logic [DATA_W-1:0] MEMWB_DatoLeido,
  output logic [ADDR_W-1:0] MEMWB_Direccion,
  output logic [REG_W-1:0]  MEMWB_MUXRes
);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  state_t state, state_next;

  logic              is_mem_op;
  logic [1:0]        wb_lat;
  logic [ADDR_W-1:0] dir_lat;
  logic [REG_W-1:0]  mux_lat;

  // A store takes priority when both MemRead and MemWrite are set.
  assign is_mem_op = EXMEM_valid & (EXMEM_MemRead | EXMEM_MemWrite);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    stall      = 1'b0;
    case (state)
      IDLE: begin
        if (is_mem_op) begin
          stall      = 1'b1;
          state_next = ACCESS;
        end
      end
      ACCESS: begin
        stall = ~mem_ack;
        if (mem_ack) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_req         <= 1'b0;
      mem_we          <= 1'b0;
      mem_addr        <= '0;
      mem_wdata       <= '0;
      wb_lat          <= 2'b00;
      dir_lat         <= '0;
      mux_lat         <= '0;
      MEM_valid       <= 1'b0;
      MEM_WB          <= 2'b00;
      MEMWB_DatoLeido <= '0;
      MEMWB_Direccion <= '0;
      MEMWB_MUXRes    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (is_mem_op) begin
            mem_req   <= 1'b1;
            mem_we    <= EXMEM_MemWrite;
            mem_addr  <= EXMEM_Direccion;
            mem_wdata <= EXMEM_DatoEscritura;
            wb_lat    <= EXMEM_WB;
            dir_lat   <= EXMEM_Direccion;
            mux_lat   <= EXMEM_MUXRes;
            MEM_valid <= 1'b0;
            MEM_WB    <= 2'b00;
          end else if (EXMEM_valid) begin
            MEM_valid       <= 1'b1;
            MEM_WB          <= EXMEM_WB;
            MEMWB_DatoLeido <= '0;
            MEMWB_Direccion <= EXMEM_Direccion;
            MEMWB_MUXRes    <= EXMEM_MUXRes;
          end else begin
            MEM_valid <= 1'b0;
            MEM_WB    <= 2'b00;
          end
        end
        ACCESS: begin
          if (mem_ack) begin
            mem_req         <= 1'b0;
            MEM_valid       <= 1'b1;
            MEM_WB          <= wb_lat;
            MEMWB_DatoLeido <= mem_we ? '0 : mem_rdata;
            MEMWB_Direccion <= dir_lat;
            MEMWB_MUXRes    <= mux_lat;
          end else begin
            MEM_valid <= 1'b0;
            MEM_WB    <= 2'b00;
          end
        end
        default: begin
          mem_req   <= 1'b0;
          MEM_valid <= 1'b0;
          MEM_WB    <= 2'b00;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MEM pipeline stage that sits directly upstream of the MEM/WB pipeline register.
- Takes the EX/MEM bundle and performs the lw/sw access on a data memory with a req/ack handshake.
- Holds the pipeline while an access is outstanding.
- Presents a registered result bundle (read data, ALU address, destination register, WB controls) for MEM/WB to latch.

Parameters:
- DATA_W, 32, data bus width.
- ADDR_W, 32, address width.
- REG_W, 5, destination register index width.

Ports:
- clk  in  1  pipeline clock; all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- EXMEM_valid  in  1  input bundle holds a real instruction (0 = bubble)
- EXMEM_WB  in  2  WB controls {RegWrite, MemtoReg}, passed through
- EXMEM_MemRead  in  1  load
- EXMEM_MemWrite  in  1  store
- EXMEM_Direccion  in  ADDR_W  ALU result / memory address
- EXMEM_DatoEscritura  in  DATA_W  store data
- EXMEM_MUXRes  in  REG_W  destination register
- mem_req  out  1  memory request, held until ack
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  write data
- mem_rdata  in  DATA_W  read data, valid when mem_ack=1
- mem_ack  in  1  access complete, one-cycle pulse
- stall  out  1  freeze upstream stages and EX/MEM
- MEM_valid  out  1  result bundle valid
- MEM_WB  out  2  WB controls to MEM/WB
- MEMWB_DatoLeido  out  DATA_W  loaded data
- MEMWB_Direccion  out  ADDR_W  ALU result passthrough
- MEMWB_MUXRes  out  REG_W  destination register

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - mem_req, mem_we, mem_addr, mem_wdata, MEM_valid, MEM_WB, MEMWB_DatoLeido, MEMWB_Direccion, MEMWB_MUXRes all 0.
  - stall=0.
  - Reset mid-access drops mem_req immediately; the access is abandoned and a later mem_ack is ignored.
- FSM has two states: IDLE and ACCESS.
- IDLE, non-memory op (EXMEM_valid=1, MemRead=MemWrite=0):
  - Next edge registers the outputs: MEM_valid=1, MEM_WB=EXMEM_WB, Direccion, MUXRes, DatoLeido=0.
  - Latency 1 cycle; stall=0.
- IDLE, memory op (EXMEM_valid=1 and MemRead|MemWrite):
  - stall=1 combinationally in this cycle.
  - Next edge: mem_req=1, mem_we=MemWrite, mem_addr=Direccion, mem_wdata=DatoEscritura; latch WB/MUXRes/Direccion internally; go to ACCESS.
  - Output registers load a bubble: MEM_valid=0, MEM_WB=2'b00, other outputs hold.
- ACCESS:
  - stall = ~mem_ack.
  - mem_req/mem_we/mem_addr/mem_wdata stay stable until ack.
  - Each cycle without ack loads a bubble into the outputs.
  - On the mem_ack edge: MEM_valid=1, MEM_WB=latched WB, Direccion/MUXRes from the latch, DatoLeido = mem_rdata for a read, 0 for a write; mem_req=0; state=IDLE.
  - Upstream advances on the same edge because stall=0 in the ack cycle.
- Minimum memory-op latency is 2 cycles (ack in the first ACCESS cycle). There is no timeout.
- EXMEM_valid=0 in IDLE: next edge loads a bubble (MEM_valid=0, MEM_WB=2'b00); stall=0.
- MemRead and MemWrite both 1: treated as a store. DatoLeido=0, and WB controls pass through unchanged.
- mem_ack while in IDLE: ignored with no state change.
- Inputs are sampled only in IDLE. Upstream changes during ACCESS have no effect.
- Bubble invariant: MEM_WB=2'b00 whenever MEM_valid=0, so WB never writes on a bubble.

Test Plan:
- Reset then R-type: Direccion=0x10, MUXRes=5, WB=2'b10, valid=1 -> next edge MEM_valid=1, MEM_WB=2'b10, MEMWB_Direccion=0x10, MUXRes=5; stall never asserted.
- Load with 3-cycle memory: lw addr 0x40, mem_ack after 3 cycles of req, rdata=0xDEADBEEF -> stall high from arrival until ack cycle; mem_addr=0x40, mem_we=0 stable; on ack edge MEM_valid=1, DatoLeido=0xDEADBEEF, MEM_WB=2'b11; bubbles (MEM_WB=0) before that.
- Store with immediate ack: sw addr 0x80, wdata 0x1234 -> mem_we=1, mem_wdata=0x1234 for one cycle; 2-cycle total; output MEM_valid=1, DatoLeido=0, MEM_WB=2'b00.
- Back-to-back lw, lw, add with 1-cycle ack -> each load costs exactly one stall cycle; add emerges one cycle after the second load's result, in order, with no lost or duplicated instruction.
- Reset mid-access: assert rst_n=0 while in ACCESS -> mem_req=0 and all outputs 0 asynchronously; after release a stray mem_ack produces no MEM_valid.
- Inputs change during ACCESS, and MemRead=MemWrite=1 case -> registered outputs reflect only the sampled bundle; the dual case performs a write with DatoLeido=0.
